fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single write port of the synchronous FIFO between `NUM_REQ` producers. Each producer presents a request plus a data word. The arbiter grants at most one producer per cycle and registers the winning word onto the FIFO `wr_en`/`data_in` pins. It never lets a write reach a full FIFO. The block sits directly in front of the FIFO, in the same clock domain.

## Interface
Parameters:
- `NUM_REQ`, 4: number of producers; 2..8.
- `FIFO_WIDTH`, 16: data word width; matches the FIFO.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `req`  in  `NUM_REQ`  per-producer write request; bit i belongs to producer i.
- `req_data`  in  `NUM_REQ` x `FIFO_WIDTH`  per-producer data; must be stable while `req[i]` is high.
- `gnt`  out  `NUM_REQ`  one-hot-or-zero grant; combinational from current inputs and state.
- `fifo_full`  in  1  FIFO full flag.
- `fifo_almostfull`  in  1  FIFO almostfull flag; high when exactly one slot is free.
- `fifo_wr_en`  out  1  registered write enable to the FIFO.
- `fifo_data_in`  out  `FIFO_WIDTH`  registered write data to the FIFO.
- `last_gnt`  out  `$clog2(NUM_REQ)`  index of the most recent winner (debug/coverage).

## Operation
- `can_grant = !fifo_full && !(fifo_wr_en && fifo_almostfull)`.
  - The second term covers the in-flight write: FIFO flags do not yet reflect the registered write.
- Search order: starting at `last_gnt+1` (mod `NUM_REQ`), the first index i with `req[i]=1` wins.
  - `gnt[i]=1` only if `can_grant`; otherwise `gnt` is all zero.
- A handshake completes on a rising edge with `req[i] && gnt[i]`:
  - `fifo_data_in <= req_data[i]`, `fifo_wr_en <= 1`, `last_gnt <= i`.
- Edge with no grant: `fifo_wr_en <= 0`. `fifo_data_in` holds its value. `last_gnt` holds.
- A producer holding `req` continuously is served once per `NUM_REQ` grants when others are requesting, so there is no starvation.
- A single requester is granted every cycle, subject to `can_grant`.
- Producer drops `req` without a grant: no effect, no state change.
- Read-side activity is ignored. The rule is conservative: a simultaneous FIFO read may free a slot, but the arbiter does not use it that cycle.

## Timing
- Reset (`rst` high at an edge):
  - `fifo_wr_en=0`, `fifo_data_in=0`, `last_gnt=NUM_REQ-1`.
  - `gnt` is forced 0 while `rst` is high.
  - After reset, producer 0 has highest priority.
- Reset asserted mid-operation: a grant visible in the same cycle is discarded. The registered write is cleared at that edge; no partial write occurs.
- Latency: grant in cycle t, then FIFO write in cycle t+1. Throughput is one write per cycle.
- Full boundary: with `fifo_almostfull=1` and `fifo_wr_en=1`, no grant is issued that cycle. With `fifo_full=1`, no grant is issued.
- `last_gnt` wrap-around: index `NUM_REQ-1` followed by index 0.

## Structure
- Shared package: `NUM_REQ`/`FIFO_WIDTH` defaults, `typedef logic [FIFO_WIDTH-1:0] fifo_word_t`, and the index width constant.
  - The FIFO and the bench reuse these.
- One sub-module, `rr_arbiter`: combinational rotating-priority search given `req`, `last_gnt`, and `enable`, returning the one-hot grant and the winner index.
- `fifo_wr_arbiter` owns the `can_grant` logic, the output register, and the `last_gnt` register.

## Test plan
- Reset: hold `rst=1` for 2 cycles with `req=4'b1111` → `gnt=0`, `fifo_wr_en=0`, `last_gnt=3`. On the first free cycle, `gnt=4'b0001`.
- Rotation: `req=4'b1111` held, FIFO empty, for 8 cycles → winners 0,1,2,3,0,1,2,3. Each `fifo_data_in` equals the winner's `req_data` one cycle later.
- Sparse/wrap: `last_gnt=2`, `req=4'b0011` → grant 0, then 1, then 0. Requester 3 is absent and skipped.
- Full protection: with DEPTH 8, streaming `req=4'b0001` and no reads → exactly 8 writes. `gnt` drops in the cycle `fifo_almostfull && fifo_wr_en` is seen; FIFO overflow never asserts.
- Recovery: from full, read one word → exactly one further grant, then stall again.
- Mid-op reset: assert `rst` in the same cycle as `gnt=4'b0100` → `fifo_wr_en=0` next cycle. No write of `req_data[2]` reaches the FIFO. `last_gnt=3`.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_wr_arbiter_pkg: shared defaults and word type for the FIFO write arbiter
package fifo_wr_arbiter_pkg;
  localparam int NUM_REQ_DEF = 4;
  localparam int FIFO_WIDTH_DEF = 16;
  localparam int IDX_W = $clog2(NUM_REQ_DEF);
  typedef logic [FIFO_WIDTH_DEF-1:0] fifo_word_t;
endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: producer-side and FIFO-side signals of the write arbiter
interface fifo_wr_arbiter_if import fifo_wr_arbiter_pkg::*; #(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF
);
  localparam int IW = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0][FIFO_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0] gnt;
  logic fifo_full;
  logic fifo_almostfull;
  logic fifo_wr_en;
  logic [FIFO_WIDTH-1:0] fifo_data_in;
  logic [IW-1:0] last_gnt;
  modport slave (input req, req_data, fifo_full, fifo_almostfull, output gnt, fifo_wr_en, fifo_data_in, last_gnt);
  modport master (output req, req_data, fifo_full, fifo_almostfull, input gnt, fifo_wr_en, fifo_data_in, last_gnt);
endinterface

// File: rtl/fifo_wr_arbiter_rr_arbiter.sv
// rr_arbiter: combinational rotating-priority search starting just after last_gnt
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_gnt,
  input  logic                       enable,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] idx
);
  localparam int IW = $clog2(NUM_REQ);
  logic [IW-1:0] cand;
  always_comb begin
    gnt = '0;
    idx = last_gnt;
    cand = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IW'((int'(last_gnt) + i) % NUM_REQ);
      if (enable && gnt == '0 && req[cand]) begin
        gnt[cand] = 1'b1;
        idx = cand;
      end
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin sharing of one FIFO write port with overflow protection
module fifo_wr_arbiter import fifo_wr_arbiter_pkg::*; #(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF
) (
  input logic clk,
  input logic rst,
  fifo_wr_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  logic can_grant;
  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0] win;
  logic wr_en_d, wr_en_q;
  logic [FIFO_WIDTH-1:0] data_d, data_q;
  logic [IW-1:0] last_gnt_d, last_gnt_q;
  // FIFO flags lag our registered write by a cycle, so almostfull plus an in-flight write means full
  assign can_grant = !rst && !bus.fifo_full && !(wr_en_q && bus.fifo_almostfull);
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req(bus.req),
    .last_gnt(last_gnt_q),
    .enable(can_grant),
    .gnt(gnt),
    .idx(win)
  );
  always_comb begin
    wr_en_d = |gnt;
    data_d = wr_en_d ? bus.req_data[win] : data_q;
    last_gnt_d = wr_en_d ? win : last_gnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q <= 1'b0;
      data_q <= '0;
      last_gnt_q <= IW'(NUM_REQ - 1);
    end else begin
      wr_en_q <= wr_en_d;
      data_q <= data_d;
      last_gnt_q <= last_gnt_d;
    end
  end
  assign bus.gnt = gnt;
  assign bus.fifo_wr_en = wr_en_q;
  assign bus.fifo_data_in = data_q;
  assign bus.last_gnt = last_gnt_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed checks of grant rotation, full protection and reset
module tb_fifo_wr_arbiter;
  import fifo_wr_arbiter_pkg::*;
  logic clk = 1'b0;
  logic rst;
  logic model_en = 1'b0;
  logic rd = 1'b0;
  logic ovf = 1'b0;
  int cnt = 0;
  int vectors = 0;
  int miscompares = 0;
  fifo_wr_arbiter_if #(.NUM_REQ(4), .FIFO_WIDTH(16)) bus ();
  fifo_wr_arbiter #(.NUM_REQ(4), .FIFO_WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // depth-8 FIFO occupancy model; disabled means an always-empty FIFO
  assign bus.fifo_full = model_en && cnt == 8;
  assign bus.fifo_almostfull = model_en && cnt == 7;
  always @(posedge clk) begin
    if (!model_en) begin
      cnt <= 0;
      ovf <= 1'b0;
    end else begin
      if (bus.fifo_wr_en && cnt == 8) ovf <= 1'b1;
      cnt <= cnt + ((bus.fifo_wr_en && cnt < 8) ? 1 : 0) - ((rd && cnt > 0) ? 1 : 0);
    end
  end
  task automatic step;
    @(posedge clk);
    #2;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    rst = 1'b1;
    bus.req = 4'b1111;
    for (int i = 0; i < 4; i++) bus.req_data[i] = fifo_word_t'(16'h1111 * (i + 1));
    step;
    step;
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_wr_en", bus.fifo_wr_en, 0);
    chk("rst_last", bus.last_gnt, 3);
    chk("rst_data", bus.fifo_data_in, 0);
    rst = 1'b0;
    #1 chk("first_gnt", bus.gnt, 4'b0001);
    for (int k = 0; k < 8; k++) begin
      chk("rot_gnt", bus.gnt, 1 << (k % 4));
      step;
      chk("rot_wr_en", bus.fifo_wr_en, 1);
      chk("rot_data", bus.fifo_data_in, 16'h1111 * (k % 4 + 1));
      chk("rot_last", bus.last_gnt, k % 4);
    end
    bus.req = 4'b0100;
    #1 chk("sp_gnt2", bus.gnt, 4'b0100);
    step;
    chk("sp_last2", bus.last_gnt, 2);
    bus.req = 4'b0011;
    #1 chk("sp_gnt0", bus.gnt, 4'b0001);
    step;
    chk("sp_last0", bus.last_gnt, 0);
    chk("sp_data0", bus.fifo_data_in, 16'h1111);
    chk("sp_gnt1", bus.gnt, 4'b0010);
    step;
    chk("sp_last1", bus.last_gnt, 1);
    chk("sp_data1", bus.fifo_data_in, 16'h2222);
    chk("sp_gnt0b", bus.gnt, 4'b0001);
    step;
    chk("sp_last0b", bus.last_gnt, 0);
    bus.req = 4'b0000;
    #1 chk("idle_gnt", bus.gnt, 0);
    step;
    chk("idle_wr_en", bus.fifo_wr_en, 0);
    chk("idle_data", bus.fifo_data_in, 16'h1111);
    chk("idle_last", bus.last_gnt, 0);
    model_en = 1'b1;
    bus.req = 4'b0001;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk("fill_gnt", bus.gnt, 4'b0001);
      step;
    end
    chk("almost_gnt", bus.gnt, 0);
    chk("almost_wr_en", bus.fifo_wr_en, 1);
    step;
    chk("full_gnt", bus.gnt, 0);
    chk("full_wr_en", bus.fifo_wr_en, 0);
    chk("full_count", cnt, 8);
    step;
    step;
    chk("full_hold_gnt", bus.gnt, 0);
    chk("full_ovf", ovf, 0);
    rd = 1'b1;
    step;
    rd = 1'b0;
    #1 chk("rec_gnt", bus.gnt, 4'b0001);
    step;
    chk("rec_wr_en", bus.fifo_wr_en, 1);
    chk("rec_stall", bus.gnt, 0);
    step;
    chk("rec_full_gnt", bus.gnt, 0);
    chk("rec_full_wr_en", bus.fifo_wr_en, 0);
    chk("rec_count", cnt, 8);
    chk("rec_ovf", ovf, 0);
    model_en = 1'b0;
    bus.req = 4'b0100;
    #1 chk("mid_gnt", bus.gnt, 4'b0100);
    rst = 1'b1;
    #1 chk("mid_rst_gnt", bus.gnt, 0);
    step;
    chk("mid_wr_en", bus.fifo_wr_en, 0);
    chk("mid_data", bus.fifo_data_in, 0);
    chk("mid_last", bus.last_gnt, 3);
    rst = 1'b0;
    bus.req = 4'b1111;
    #1 chk("post_gnt", bus.gnt, 4'b0001);
    step;
    chk("post_data", bus.fifo_data_in, 16'h1111);
    chk("post_last", bus.last_gnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
